// File: rtl/cva6_axi_mem_responder.sv
// AXI4 memory responder: independent write/read FSMs over a 64-bit word array.
// Optional CVA6_AXI_MEM_RANGE_CHECK_EN flags out-of-range beats as SLVERR.
package cva6_axi_mem_responder_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        axi_b_t b;
        logic   b_valid;
        axi_r_t r;
        logic   r_valid;
    } axi_resp_t;
endpackage

module cva6_axi_mem_responder
    import cva6_axi_mem_responder_pkg::*;
#(
    parameter type         mst_req_t   = axi_req_t,
    parameter type         mst_resp_t  = axi_resp_t,
    parameter int unsigned MemWords    = 1024,
    parameter int unsigned ReadLatency = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  mst_req_t  axi_req_i,
    output mst_resp_t axi_resp_o
);
    localparam int unsigned IdxW = $clog2(MemWords);
    localparam logic [3:0] LatLast =
        (ReadLatency == 0) ? 4'd0 : 4'(ReadLatency - 1);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
`ifdef CVA6_AXI_MEM_RANGE_CHECK_EN
    localparam bit RangeCheck = 1'b1;
`else
    localparam bit RangeCheck = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    function automatic logic out_of_range(input logic [63:0] a);
        return RangeCheck && (a[63:3+IdxW] != '0);
    endfunction

    function automatic logic [63:0] next_addr(input logic [63:0] a,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        return (burst == 2'b00) ? a : a + (64'd1 << size);
    endfunction

    logic [63:0] mem_q [MemWords];

    w_state_e    w_state_q;
    logic [3:0]  w_id_q;
    logic [63:0] w_addr_q;
    logic [7:0]  w_len_q, w_cnt_q;
    logic [2:0]  w_size_q;
    logic [1:0]  w_burst_q, b_resp_q;
    logic        w_err_q, aw_ready_q, w_ready_q, b_valid_q;

    r_state_e    r_state_q;
    logic [3:0]  r_id_q, lat_q;
    logic [63:0] r_addr_q;
    logic [7:0]  r_len_q, r_cnt_q;
    logic [2:0]  r_size_q;
    logic [1:0]  r_burst_q;
    logic        ar_ready_q, r_valid_q, r_last_q;

    logic            w_bad, w_last_beat, w_beat_err, mem_we;
    logic            r_bad;
    logic [IdxW-1:0] w_idx, r_idx;

    assign w_idx       = w_addr_q[3 +: IdxW];
    assign r_idx       = r_addr_q[3 +: IdxW];
    assign w_bad       = w_burst_q[1] || out_of_range(w_addr_q);
    assign r_bad       = r_burst_q[1] || out_of_range(r_addr_q);
    assign w_last_beat = (w_cnt_q == w_len_q);
    assign w_beat_err  = w_bad || (axi_req_i.w.last != w_last_beat);
    assign mem_we      = w_ready_q && axi_req_i.w_valid && !w_bad;

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (axi_req_i.w.strb[i]) begin
                    mem_q[w_idx][8*i +: 8] <= axi_req_i.w.data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q  <= W_IDLE;
            w_id_q     <= '0;
            w_addr_q   <= '0;
            w_len_q    <= '0;
            w_cnt_q    <= '0;
            w_size_q   <= '0;
            w_burst_q  <= '0;
            w_err_q    <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= OKAY;
        end else begin
            unique case (w_state_q)
                W_IDLE: if (axi_req_i.aw_valid) begin
                    w_id_q     <= axi_req_i.aw.id;
                    w_addr_q   <= axi_req_i.aw.addr;
                    w_len_q    <= axi_req_i.aw.len;
                    w_size_q   <= axi_req_i.aw.size;
                    w_burst_q  <= axi_req_i.aw.burst;
                    w_cnt_q    <= '0;
                    w_err_q    <= 1'b0;
                    aw_ready_q <= 1'b0;
                    w_ready_q  <= 1'b1;
                    w_state_q  <= W_DATA;
                end
                W_DATA: if (axi_req_i.w_valid) begin
                    w_cnt_q  <= w_cnt_q + 8'd1;
                    w_addr_q <= next_addr(w_addr_q, w_size_q, w_burst_q);
                    w_err_q  <= w_err_q || w_beat_err;
                    // Beat count alone ends the burst; a stray last only flags.
                    if (w_last_beat) begin
                        w_ready_q <= 1'b0;
                        b_valid_q <= 1'b1;
                        b_resp_q  <= (w_err_q || w_beat_err) ? SLVERR : OKAY;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: if (axi_req_i.b_ready) begin
                    b_valid_q  <= 1'b0;
                    aw_ready_q <= 1'b1;
                    w_state_q  <= W_IDLE;
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q  <= R_IDLE;
            r_id_q     <= '0;
            r_addr_q   <= '0;
            r_len_q    <= '0;
            r_cnt_q    <= '0;
            r_size_q   <= '0;
            r_burst_q  <= '0;
            lat_q      <= '0;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
        end else begin
            unique case (r_state_q)
                R_IDLE: if (axi_req_i.ar_valid) begin
                    r_id_q     <= axi_req_i.ar.id;
                    r_addr_q   <= axi_req_i.ar.addr;
                    r_len_q    <= axi_req_i.ar.len;
                    r_size_q   <= axi_req_i.ar.size;
                    r_burst_q  <= axi_req_i.ar.burst;
                    r_cnt_q    <= '0;
                    lat_q      <= '0;
                    ar_ready_q <= 1'b0;
                    if (ReadLatency == 0) begin
                        r_valid_q <= 1'b1;
                        r_last_q  <= (axi_req_i.ar.len == 8'd0);
                        r_state_q <= R_DATA;
                    end else begin
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: if (lat_q == LatLast) begin
                    r_valid_q <= 1'b1;
                    r_last_q  <= (r_len_q == 8'd0);
                    r_state_q <= R_DATA;
                end else begin
                    lat_q <= lat_q + 4'd1;
                end
                R_DATA: if (axi_req_i.r_ready) begin
                    if (r_last_q) begin
                        r_valid_q  <= 1'b0;
                        r_last_q   <= 1'b0;
                        ar_ready_q <= 1'b1;
                        r_state_q  <= R_IDLE;
                    end else begin
                        r_cnt_q  <= r_cnt_q + 8'd1;
                        r_addr_q <= next_addr(r_addr_q, r_size_q, r_burst_q);
                        r_last_q <= ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // Read data is combinational so same-cycle writes show up next cycle.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready_q;
        axi_resp_o.w_ready  = w_ready_q;
        axi_resp_o.b_valid  = b_valid_q;
        axi_resp_o.b.id     = w_id_q;
        axi_resp_o.b.resp   = b_resp_q;
        axi_resp_o.ar_ready = ar_ready_q;
        axi_resp_o.r_valid  = r_valid_q;
        axi_resp_o.r.id     = r_id_q;
        axi_resp_o.r.last   = r_last_q;
        axi_resp_o.r.resp   = (r_valid_q && r_bad) ? SLVERR : OKAY;
        axi_resp_o.r.data   = (r_valid_q && !r_bad) ? mem_q[r_idx] : 64'd0;
    end
endmodule

// File: tb/tb_cva6_axi_mem_responder.sv
// Directed bench for cva6_axi_mem_responder with a read-data scoreboard
// and a reference word model updated on every accepted write beat.
module tb_cva6_axi_mem_responder;
    import cva6_axi_mem_responder_pkg::*;

    localparam int RL = 2;
    localparam int MW = 1024;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] ERR = 2'b10;
    localparam logic [1:0] FIX = 2'b00;
    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] WRP = 2'b10;
`ifdef CVA6_AXI_MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [63:0] d;
        logic [1:0]  r;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    axi_req_t  req;
    axi_resp_t resp;
    int        checks = 0;
    int        errors = 0;
    exp_t      sb[$];
    logic [63:0] model [MW];

    cva6_axi_mem_responder #(
        .mst_req_t  (axi_req_t),
        .mst_resp_t (axi_resp_t),
        .MemWords   (MW),
        .ReadLatency(RL)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .axi_req_i (req),
        .axi_resp_o(resp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bad(input logic [63:0] a, input logic [1:0] bu);
        return bu[1] || (RC && ((a >> 3) >= 64'(MW)));
    endfunction

    function automatic logic [63:0] nxt(input logic [63:0] a,
                                        input logic [1:0] bu);
        return (bu == FIX) ? a : a + 64'd8;
    endfunction

    task automatic wr(input logic [3:0] id, input logic [63:0] addr,
                      input logic [7:0] len, input logic [1:0] bu,
                      input logic [63:0] base, input logic [7:0] strb,
                      input int last_at, input logic [1:0] exp_resp);
        int n;
        logic [63:0] a, d;
        req.aw = '{id: id, addr: addr, len: len, size: 3'd3, burst: bu};
        req.aw_valid = 1'b1;
        n = 0;
        while (!resp.aw_ready && n < 20) begin @(negedge clk); n++; end
        chk("aw_ready", 64'(resp.aw_ready), 64'd1);
        @(negedge clk);
        req.aw_valid = 1'b0;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            d = base + 64'(i);
            req.w = '{data: d, strb: strb, last: (i == last_at)};
            req.w_valid = 1'b1;
            n = 0;
            while (!resp.w_ready && n < 20) begin @(negedge clk); n++; end
            chk("w_ready", 64'(resp.w_ready), 64'd1);
            if (!bad(a, bu)) begin
                for (int b = 0; b < 8; b++) begin
                    if (strb[b]) model[a[12:3]][8*b +: 8] = d[8*b +: 8];
                end
            end
            a = nxt(a, bu);
            @(negedge clk);
        end
        req.w_valid = 1'b0;
        chk("b_valid", 64'(resp.b_valid), 64'd1);
        chk("w_ready_off", 64'(resp.w_ready), 64'd0);
        chk("b_id", 64'(resp.b.id), 64'(id));
        chk("b_resp", 64'(resp.b.resp), 64'(exp_resp));
        req.b_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        chk("b_valid_clr", 64'(resp.b_valid), 64'd0);
        chk("aw_ready_back", 64'(resp.aw_ready), 64'd1);
    endtask

    task automatic rd(input logic [3:0] id, input logic [63:0] addr,
                      input logic [7:0] len, input logic [1:0] bu,
                      input int stall, input int abort_at);
        int n;
        logic [63:0] a;
        exp_t e;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            if (bad(a, bu)) sb.push_back('{d: 64'd0, r: ERR});
            else sb.push_back('{d: model[a[12:3]], r: OK});
            a = nxt(a, bu);
        end
        req.ar = '{id: id, addr: addr, len: len, size: 3'd3, burst: bu};
        req.ar_valid = 1'b1;
        n = 0;
        while (!resp.ar_ready && n < 20) begin @(negedge clk); n++; end
        chk("ar_ready", 64'(resp.ar_ready), 64'd1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        n = 1;
        while (!resp.r_valid && n < 40) begin @(negedge clk); n++; end
        chk("r_latency", 64'(n), 64'(1 + RL));
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!resp.r_valid && n < 40) begin @(negedge clk); n++; end
            chk("r_valid", 64'(resp.r_valid), 64'd1);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
                chk("rst_r_last", 64'(resp.r.last), 64'd0);
                chk("rst_ar_ready", 64'(resp.ar_ready), 64'd1);
                sb.delete();
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_ar_ready", 64'(resp.ar_ready), 64'd1);
                chk("post_rst_r_valid", 64'(resp.r_valid), 64'd0);
                return;
            end
            e = sb.pop_front();
            chk("r_data", resp.r.data, e.d);
            chk("r_resp", 64'(resp.r.resp), 64'(e.r));
            chk("r_id", 64'(resp.r.id), 64'(id));
            chk("r_last", 64'(resp.r.last), 64'(i == int'(len)));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("r_hold_valid", 64'(resp.r_valid), 64'd1);
                chk("r_hold_data", resp.r.data, e.d);
                chk("r_hold_last", 64'(resp.r.last), 64'(i == int'(len)));
            end
            req.r_ready = 1'b1;
            @(negedge clk);
            req.r_ready = 1'b0;
        end
        chk("r_done", 64'(resp.r_valid), 64'd0);
        chk("ar_ready_back", 64'(resp.ar_ready), 64'd1);
    endtask

    initial begin
        int n;
        req = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_aw_ready", 64'(resp.aw_ready), 64'd1);
        chk("rst_ar_ready", 64'(resp.ar_ready), 64'd1);
        chk("rst_w_ready", 64'(resp.w_ready), 64'd0);
        chk("rst_b_valid", 64'(resp.b_valid), 64'd0);
        chk("rst_r_valid", 64'(resp.r_valid), 64'd0);
        chk("rst_r_last", 64'(resp.r.last), 64'd0);
        chk("rst_b_resp", 64'(resp.b.resp), 64'd0);
        chk("rst_r_resp", 64'(resp.r.resp), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        wr(4'd3, 64'h100, 8'd3, INC, 64'd1, 8'hFF, 3, OK);
        rd(4'd3, 64'h100, 8'd3, INC, 0, -1);
        rd(4'd5, 64'h108, 8'd0, INC, 3, -1);

        wr(4'd1, 64'h200, 8'd0, INC, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, OK);
        wr(4'd1, 64'h200, 8'd0, INC, 64'd0, 8'h0F, 0, OK);
        rd(4'd1, 64'h200, 8'd0, INC, 0, -1);
        chk("strb_merge", model[64], 64'hFFFF_FFFF_0000_0000);

        wr(4'd2, 64'h300, 8'd2, INC, 64'd10, 8'hFF, 1, ERR);
        rd(4'd2, 64'h300, 8'd2, INC, 0, -1);
        wr(4'd6, 64'h380, 8'd1, INC, 64'd20, 8'hFF, -1, ERR);

        wr(4'd4, 64'h0, 8'd0, INC, 64'h1234_5678, 8'hFF, 0, OK);
        rd(4'd4, 64'h2000, 8'd0, INC, 0, -1);

        wr(4'd7, 64'h100, 8'd1, WRP, 64'd99, 8'hFF, 1, ERR);
        rd(4'd7, 64'h100, 8'd1, INC, 0, -1);
        rd(4'd8, 64'h100, 8'd1, WRP, 0, -1);

        wr(4'd9, 64'h500, 8'd2, FIX, 64'd40, 8'hFF, 2, OK);
        rd(4'd9, 64'h500, 8'd1, FIX, 0, -1);

        wr(4'd12, 64'h600, 8'd0, INC, 64'hAAAA, 8'hFF, 0, OK);
        req.ar = '{id: 4'd12, addr: 64'h600, len: 8'd0, size: 3'd3, burst: INC};
        req.ar_valid = 1'b1;
        @(negedge clk);
        req.ar_valid = 1'b0;
        n = 0;
        while (!resp.r_valid && n < 40) begin @(negedge clk); n++; end
        chk("same_r_valid", 64'(resp.r_valid), 64'd1);
        req.aw = '{id: 4'd12, addr: 64'h600, len: 8'd0, size: 3'd3, burst: INC};
        req.aw_valid = 1'b1;
        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w = '{data: 64'h5555, strb: 8'hFF, last: 1'b1};
        req.w_valid = 1'b1;
        chk("same_w_ready", 64'(resp.w_ready), 64'd1);
        chk("same_old_data", resp.r.data, model[192]);
        @(negedge clk);
        req.w_valid = 1'b0;
        model[192] = 64'h5555;
        chk("same_new_data", resp.r.data, model[192]);
        chk("same_b_valid", 64'(resp.b_valid), 64'd1);
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        @(negedge clk);
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        chk("same_r_done", 64'(resp.r_valid), 64'd0);
        chk("same_b_done", 64'(resp.b_valid), 64'd0);

        rd(4'd10, 64'h100, 8'd3, INC, 0, 1);
        rd(4'd11, 64'h100, 8'd3, INC, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
